// File: rtl/cursor_editor_pkg.sv
// Shared definitions for the cursor editor, the life game board and the
// renderer: button bit positions, default grid size and repeater states.
package cursor_editor_pkg;

  // Bit positions inside the 4-bit button bus {left, right, up, down}.
  localparam int LEFT  = 3;
  localparam int RIGHT = 2;
  localparam int UP    = 1;
  localparam int DOWN  = 0;

  // Default cell grid size.
  localparam int DEFAULT_GRID_WIDTH  = 32;
  localparam int DEFAULT_GRID_HEIGHT = 24;

  // Per-button auto-repeat state.
  typedef enum logic [1:0] {
    REP_IDLE   = 2'd0,
    REP_DELAY  = 2'd1,
    REP_REPEAT = 2'd2
  } rep_state_t;

  // Larger of two cycle counts; sizes the repeat counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_repeater.sv
// Turns one debounced button level into step pulses: one on press, a first
// repeat REPEAT_DELAY cycles later, then one every REPEAT_RATE cycles while held.
module key_repeater
  import cursor_editor_pkg::*;
#(
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic level,
  output logic step
);

  localparam int CNT_BITS = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE));
  localparam logic [CNT_BITS-1:0] DELAY_LOAD = CNT_BITS'(REPEAT_DELAY - 1);
  localparam logic [CNT_BITS-1:0] RATE_LOAD  = CNT_BITS'(REPEAT_RATE - 1);

  rep_state_t          state;
  logic [CNT_BITS-1:0] count;
  logic                level_q;

  // Press detection, repeat timing and the registered step pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= REP_IDLE;
      count   <= '0;
      level_q <= 1'b0;
      step    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      level_q <= level;
      step    <= 1'b0;
      case (state)
        REP_IDLE: begin
          if (level && !level_q) begin
            step  <= 1'b1;
            count <= DELAY_LOAD;
            state <= REP_DELAY;
          end
        end
        REP_DELAY, REP_REPEAT: begin
          if (!level) begin
            state <= REP_IDLE;
            count <= '0;
          end else if (count == '0) begin
            step  <= 1'b1;
            count <= RATE_LOAD;
            state <= REP_REPEAT;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: begin
          state <= REP_IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/cursor_editor.sv
// Front-panel board editor: moves a wrapping (x, y) cursor from the button
// repeaters and raises valid/ready toggle-cell requests at the cursor.
module cursor_editor
  import cursor_editor_pkg::*;
#(
  parameter int GRID_WIDTH   = DEFAULT_GRID_WIDTH,
  parameter int GRID_HEIGHT  = DEFAULT_GRID_HEIGHT,
  parameter int X_BITS       = 5,
  parameter int Y_BITS       = 5,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              edit_enable,
  input  logic [3:0]        button,
  input  logic              toggle_button,
  output logic [X_BITS-1:0] cursor_x,
  output logic [Y_BITS-1:0] cursor_y,
  output logic              toggle_valid,
  output logic [X_BITS-1:0] toggle_x,
  output logic [Y_BITS-1:0] toggle_y,
  input  logic              toggle_ready
);

  localparam logic [X_BITS-1:0] X_MAX = X_BITS'(GRID_WIDTH - 1);
  localparam logic [Y_BITS-1:0] Y_MAX = Y_BITS'(GRID_HEIGHT - 1);

  logic [3:0]        step;
  logic [X_BITS-1:0] x_next;
  logic [Y_BITS-1:0] y_next;
  logic              toggle_q;
  logic              toggle_press;

  for (genvar i = 0; i < 4; i++) begin : g_rep
    key_repeater #(
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_rep (
      .clock  (clock),
      .reset_n(reset_n),
      .level  (button[i]),
      .step   (step[i])
    );
  end

  // Next cursor position: opposing steps cancel, x and y move independently.
  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    x_next = cursor_x;
    y_next = cursor_y;
    if (edit_enable) begin
      if (step[LEFT] && !step[RIGHT])
        x_next = (cursor_x == '0) ? X_MAX : cursor_x - 1'b1;
      else if (step[RIGHT] && !step[LEFT])
        x_next = (cursor_x == X_MAX) ? '0 : cursor_x + 1'b1;
      if (step[UP] && !step[DOWN])
        y_next = (cursor_y == '0) ? Y_MAX : cursor_y - 1'b1;
      else if (step[DOWN] && !step[UP])
        y_next = (cursor_y == Y_MAX) ? '0 : cursor_y + 1'b1;
    end
  end

  assign toggle_press = toggle_button && !toggle_q;

  // Cursor registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cursor_x <= '0;
      cursor_y <= '0;
    end else begin
      cursor_x <= x_next;
      cursor_y <= y_next;
    end
  end

  // Toggle request: latch the pre-edge cursor on a press, hold until accepted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      toggle_q     <= 1'b0;
      toggle_valid <= 1'b0;
      toggle_x     <= '0;
      toggle_y     <= '0;
    end else begin
      toggle_q <= toggle_button;
      if (toggle_valid) begin
        if (toggle_ready) toggle_valid <= 1'b0;
      end else if (toggle_press && edit_enable) begin
        toggle_valid <= 1'b1;
        toggle_x     <= cursor_x;
        toggle_y     <= cursor_y;
      end
    end
  end

endmodule
